// File: rtl/fp_sub_pkg.sv
// fp_sub_pkg: shared state encoding and field widths for the magnitude subtractor
package fp_sub_pkg;
  typedef enum logic [1:0] {IDLE, ALIGN, NORM, DONE} state_t;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam logic [31:0] ZERO_FP = 32'h0;
endpackage

// File: rtl/fp_lzc24.sv
// fp_lzc24: combinational leading-zero count of a 24-bit mantissa (24 when m is zero)
//   m  : mantissa in
//   lz : number of leading zeros
module fp_lzc24
  import fp_sub_pkg::*;
(
  input  logic [MANT_W-1:0] m,
  output logic [4:0]        lz
);
  always_comb begin
    lz = 5'd24;
    for (int i = 0; i < MANT_W; i++)
      if (m[i]) lz = 5'(MANT_W - 1 - i);
  end
endmodule

// File: rtl/fp_sub.sv
// fp_sub: multi-cycle single-precision |FA| - |FB| with valid/ready handshakes
//   clk, rst (sync, active high); FA, FB operands; in_valid/in_ready input handshake;
//   FD result, out_valid/out_ready output handshake.
//   FP_SUB_FAST_NORM_EN: one-cycle normalize via fp_lzc24 instead of a bit-per-cycle loop.
module fp_sub
  import fp_sub_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] FA,
  input  logic [31:0] FB,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] FD,
  output logic        out_valid,
  input  logic        out_ready
);
  state_t state, state_nx;
  logic [30:0] a, b, l, s;
  logic sign, swap, norm_done, unused;
  logic [EXP_W-1:0] exp, sh;
  logic [MANT_W-1:0] mant, ms;
  logic [31:0] res;
  assign swap = b > a;
  assign l = swap ? b : a;
  assign s = swap ? a : b;
  assign sh = l[30:23] - s[30:23];
  assign ms = sh >= 8'(MANT_W) ? '0 : {1'b1, s[22:0]} >> sh;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
`ifdef FP_SUB_FAST_NORM_EN
  logic [4:0] lz;
  logic [MANT_W-1:0] mant_n;
  fp_lzc24 u_lzc (.m(mant), .lz(lz));
  assign mant_n = mant << lz;
  assign norm_done = 1'b1;
  // lz >= exp means the exponent would reach zero: flush
  assign res = (mant == '0 || {3'b0, lz} >= exp) ? ZERO_FP : {sign, exp - {3'b0, lz}, mant_n[FRAC_W-1:0]};
  assign unused = ^{FA[31], FB[31], mant_n[MANT_W-1]};
`else
  // an exponent hitting zero before the hidden bit reappears ends the loop and flushes
  assign norm_done = mant[MANT_W-1] || mant == '0 || exp == '0;
  assign res = (mant == '0 || exp == '0) ? ZERO_FP : {sign, exp, mant[FRAC_W-1:0]};
  assign unused = ^{FA[31], FB[31]};
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = in_valid ? ALIGN : IDLE;
      ALIGN: state_nx = NORM;
      NORM:  state_nx = norm_done ? DONE : NORM;
      DONE:  state_nx = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      sign <= 1'b0;
      exp <= '0;
      mant <= '0;
      FD <= ZERO_FP;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a <= FA[30:0];
          b <= FB[30:0];
        end
        ALIGN: begin
          sign <= swap;
          exp <= l[30:23];
          mant <= {1'b1, l[22:0]} - ms;
        end
        NORM: if (norm_done) FD <= res;
          else begin
            mant <= mant << 1;
            exp <= exp - 1'b1;
          end
        DONE: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_sub.sv
// tb_fp_sub: directed scoreboard bench for fp_sub
module tb_fp_sub;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [31:0] FA = 0, FB = 0;
  logic in_ready, out_valid;
  logic [31:0] FD;
  typedef struct { logic [31:0] fd; int lat; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  fp_sub dut (.clk(clk), .rst(rst), .FA(FA), .FB(FB), .in_valid(in_valid), .in_ready(in_ready),
              .FD(FD), .out_valid(out_valid), .out_ready(out_ready));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  function automatic int lat_of(input int k);
`ifdef FP_SUB_FAST_NORM_EN
    return 3;
`else
    return 3 + k;
`endif
  endfunction
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] fd, input int k);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    FA = a;
    FB = b;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    sb.push_back('{fd, lat_of(k)});
  endtask
  task automatic collect(input string tag, input bit release_out);
    int n = 0;
    exp_t e;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    e = sb.pop_front();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_fd"}, FD, e.fd);
    check({tag, "_lat"}, 32'(n + 1), 32'(e.lat));
    if (release_out) begin
      @(negedge clk);
      out_ready = 1;
      @(posedge clk);
      #1 out_ready = 0;
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fd", FD, 32'h0);
    rst = 0;
    issue(32'h40400000, 32'h3F800000, 32'h40000000, 0);
    collect("three_minus_one", 1);
    issue(32'h3F800000, 32'h3F800000, 32'h00000000, 0);
    collect("equal", 1);
    issue(32'h3F800000, 32'h40400000, 32'hC0000000, 0);
    collect("neg", 1);
    issue(32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 23);
    collect("lz23", 1);
    issue(32'h50000000, 32'h3F800000, 32'h50000000, 0);
    collect("far_shift", 1);
    issue(32'hBF800000, 32'h3F000000, 32'h3F000000, 1);
    collect("sign_ignored", 1);
    issue(32'h40400000, 32'h3F800000, 32'h40000000, 0);
    collect("stall", 0);
    @(negedge clk);
    FA = 32'h3F800000;
    FB = 32'h3F800000;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_fd", FD, 32'h40000000);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    issue(32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 23);
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    void'(sb.pop_back());
    check("midnorm_rst_in_ready", 32'(in_ready), 32'd1);
    check("midnorm_rst_out_valid", 32'(out_valid), 32'd0);
    check("midnorm_rst_fd", FD, 32'h0);
    issue(32'h40400000, 32'h3F800000, 32'h40000000, 0);
    collect("after_rst", 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
